// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_pkg
// Brief    : Shared state encoding, error codes and framing constants for the
//            instruction-memory stream loader.
// Revision : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LEN_LO = 4'd1,
        LEN_HI = 4'd2,
        B0     = 4'd3,
        B1     = 4'd4,
        B2     = 4'd5,
        WRITE  = 4'd6,
        CHK    = 4'd7,
        DONE   = 4'd8,
        ERR    = 4'd9
    } loader_state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_PAD  = 2'd2;
    localparam logic [1:0] ERR_CHK  = 2'd3;

    localparam int BYTES_PER_WORD = 3;

endpackage
`default_nettype wire

// File: rtl/imem_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : imem_word_packer
// Brief    : Holds B0/B1 of a word and merges the B2 byte currently on the
//            stream to form the packed instruction plus its pad-bit check.
// Revision : 1.0 - initial release
// ============================================================================
module imem_word_packer
    import imem_loader_pkg::*;
#(
    parameter int WORD_W = 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              load_b0,
    input  logic              load_b1,
    output logic [WORD_W-1:0] word,
    output logic              pad_err
);

    localparam int c_BUF_W = 8 * BYTES_PER_WORD;

    logic [15:0]        r_lo;
    logic [c_BUF_W-1:0] w_buf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lo <= '0;
        end else begin
            if (load_b0) r_lo[7:0]  <= in_data;
            if (load_b1) r_lo[15:8] <= in_data;
        end
    end

    // B2 is used straight off the bus so the word is ready on its handshake edge
    assign w_buf   = {in_data, r_lo};
    assign word    = w_buf[WORD_W-1:0];
    assign pad_err = |w_buf[c_BUF_W-1:WORD_W];

endmodule
`default_nettype wire

// File: rtl/imem_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_stream_loader
// Brief    : Unpacks a length/checksum framed byte stream into 22-bit words
//            and drives the instruction memory write port.
// Revision : 1.0 - initial release
// ============================================================================
module imem_stream_loader
    import imem_loader_pkg::*;
#(
    parameter int WORD_W = 22,
    parameter int ADDR_W = 22,
    parameter int DEPTH  = 101
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] wa,
    output logic [WORD_W-1:0] wd,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam logic [15:0] c_DEPTH = 16'(DEPTH);

    loader_state_t      r_state;
    loader_state_t      w_next;
    logic [15:0]        r_len;
    logic [15:0]        r_idx;
    logic [7:0]         r_chk;
    logic [1:0]         r_err_code;
    logic               r_we;
    logic [ADDR_W-1:0]  r_wa;
    logic [WORD_W-1:0]  r_wd;

    logic               w_acc;
    logic               w_idle_like;
    logic [15:0]        w_len_n;
    logic [15:0]        w_idx_inc;
    logic               w_len_big;
    logic [WORD_W-1:0]  w_word;
    logic               w_pad_err;

    assign w_acc       = in_valid & in_ready;
    assign w_idle_like = (r_state == IDLE) || (r_state == DONE) || (r_state == ERR);
    assign w_len_n     = {in_data, r_len[7:0]};
    assign w_idx_inc   = r_idx + 16'd1;
    assign w_len_big   = (w_len_n > c_DEPTH);

    imem_word_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk     (clk),
        .reset   (reset),
        .in_data (in_data),
        .load_b0 (w_acc && (r_state == B0)),
        .load_b1 (w_acc && (r_state == B1)),
        .word    (w_word),
        .pad_err (w_pad_err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        busy     = 1'b1;
        case (r_state)
            IDLE, DONE, ERR: begin
                busy = 1'b0;
                if (start) w_next = LEN_LO;
            end
            LEN_LO: begin
                in_ready = 1'b1;
                if (w_acc) w_next = LEN_HI;
            end
            LEN_HI: begin
                in_ready = 1'b1;
                if (w_acc) begin
                    if (w_len_n == 16'd0) w_next = CHK;
                    else if (w_len_big)   w_next = ERR;
                    else                  w_next = B0;
                end
            end
            B0: begin
                in_ready = 1'b1;
                if (w_acc) w_next = B1;
            end
            B1: begin
                in_ready = 1'b1;
                if (w_acc) w_next = B2;
            end
            B2: begin
                in_ready = 1'b1;
                if (w_acc) w_next = w_pad_err ? ERR : WRITE;
            end
            WRITE: begin
                w_next = (w_idx_inc == r_len) ? CHK : B0;
            end
            CHK: begin
                in_ready = 1'b1;
                if (w_acc) w_next = (in_data == r_chk) ? DONE : ERR;
            end
            default: begin
                busy   = 1'b0;
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len      <= '0;
            r_idx      <= '0;
            r_chk      <= '0;
            r_err_code <= ERR_NONE;
            r_we       <= 1'b0;
            r_wa       <= '0;
            r_wd       <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        r_len      <= '0;
                        r_idx      <= '0;
                        r_chk      <= '0;
                        r_err_code <= ERR_NONE;
                    end
                end
                LEN_LO: if (w_acc) r_len[7:0] <= in_data;
                LEN_HI: begin
                    if (w_acc) begin
                        r_len[15:8] <= in_data;
                        if (w_len_big) r_err_code <= ERR_LEN;
                    end
                end
                B0, B1: if (w_acc) r_chk <= r_chk ^ in_data;
                B2: begin
                    if (w_acc) begin
                        r_chk <= r_chk ^ in_data;
                        // A bad pad byte aborts before anything reaches memory
                        if (w_pad_err) begin
                            r_err_code <= ERR_PAD;
                        end else begin
                            r_we <= 1'b1;
                            r_wa <= ADDR_W'({r_idx, 2'b00});
                            r_wd <= w_word;
                        end
                    end
                end
                WRITE: r_idx <= w_idx_inc;
                CHK: begin
                    if (w_acc && (in_data != r_chk)) r_err_code <= ERR_CHK;
                end
                default: ;
            endcase
        end
    end

    assign we       = r_we;
    assign wa       = r_wa;
    assign wd       = r_wd;
    assign done     = (r_state == DONE);
    assign error    = (r_state == ERR);
    assign err_code = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_imem_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_stream_loader
// Brief    : Directed self-checking bench for the instruction stream loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_stream_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        we;
    logic [21:0] wa;
    logic [21:0] wd;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;

    int checks = 0;
    int failures = 0;
    int wr_ready_bad = 0;
    logic [21:0] q_wa[$];
    logic [21:0] q_wd[$];
    logic [7:0]  fr[$];

    imem_stream_loader #(.WORD_W(22), .ADDR_W(22), .DEPTH(101)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    // Write-port monitor; also records any cycle where a byte could be taken during a write
    always @(negedge clk) begin
        if (we === 1'b1) begin
            q_wa.push_back(wa);
            q_wd.push_back(wd);
            if (in_ready !== 1'b0) wr_ready_bad++;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        in_data  = b;
        in_valid = 1'b1;
        for (t = 0; t < 200; t++) begin
            if (in_ready === 1'b1) break;
            @(negedge clk);
        end
        checks++;
        if (t == 200) begin
            failures++;
            $display("FAIL send_byte timeout: in_ready=%b required 1 for byte %h", in_ready, b);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // start_at >= 0 pulses start during the gap after that byte index
    task automatic send_frame(input int gap, input int start_at);
        for (int i = 0; i < fr.size(); i++) begin
            send_byte(fr[i]);
            if (i == start_at) pulse_start();
            repeat (gap) @(negedge clk);
        end
        #1;
    endtask

    task automatic clear_log();
        q_wa.delete();
        q_wd.delete();
        wr_ready_bad = 0;
    endtask

    task automatic hard_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_two_writes(input string tag);
        checks++;
        if (q_wa.size() != 2) begin
            failures++;
            $display("FAIL %s write count: got %0d required 2", tag, q_wa.size());
        end else begin
            checks++;
            if (q_wa[0] !== 22'h0 || q_wd[0] !== 22'h268088) begin
                failures++;
                $display("FAIL %s word0: got wa=%h wd=%h required wa=000000 wd=268088", tag, q_wa[0], q_wd[0]);
            end
            checks++;
            if (q_wa[1] !== 22'h4 || q_wd[1] !== 22'h268109) begin
                failures++;
                $display("FAIL %s word1: got wa=%h wd=%h required wa=000004 wd=268109", tag, q_wa[1], q_wd[1]);
            end
        end
        checks++;
        if (wr_ready_bad != 0) begin
            failures++;
            $display("FAIL %s in_ready during write: got %0d cycles required 0", tag, wr_ready_bad);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({we, wa, wd, busy, done, error, err_code, in_ready} !== 50'd0) begin
            failures++;
            $display("FAIL reset outputs: got we=%b wa=%h wd=%h busy=%b done=%b error=%b code=%0d rdy=%b required all 0",
                     we, wa, wd, busy, done, error, err_code, in_ready);
        end
        reset = 1'b0;
        @(negedge clk);
        send_byte_idle_check();
    endtask

    // A byte offered in IDLE alongside start must not be consumed
    task automatic send_byte_idle_check();
        in_data = 8'h02; in_valid = 1'b1; start = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle in_ready: got %b required 0", in_ready);
        end
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL start to LEN_LO: got busy=%b rdy=%b required 1 1", busy, in_ready);
        end
        hard_reset();
    endtask

    task automatic test_load_two();
        clear_log();
        pulse_start();
        fr = '{8'h02, 8'h00, 8'h88, 8'h80, 8'h26, 8'h09, 8'h81, 8'h26, 8'h80};
        send_frame(0, -1);
        check_two_writes("load_two");
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0 || err_code !== 2'd0) begin
            failures++;
            $display("FAIL load_two status: got done=%b busy=%b error=%b code=%0d required 1 0 0 0", done, busy, error, err_code);
        end
    endtask

    task automatic test_len_too_big();
        clear_log();
        pulse_start();
        fr = '{8'h66, 8'h00};
        send_frame(0, -1);
        repeat (3) @(negedge clk);
        checks++;
        if (error !== 1'b1 || err_code !== 2'd1 || in_ready !== 1'b0 || busy !== 1'b0 || q_wa.size() != 0) begin
            failures++;
            $display("FAIL len_too_big: got error=%b code=%0d rdy=%b busy=%b writes=%0d required 1 1 0 0 0",
                     error, err_code, in_ready, busy, q_wa.size());
        end
        // N == DEPTH is the largest frame accepted
        pulse_start();
        checks++;
        if (error !== 1'b0 || err_code !== 2'd0) begin
            failures++;
            $display("FAIL start clears error: got error=%b code=%0d required 0 0", error, err_code);
        end
        fr = '{8'h65, 8'h00};
        send_frame(0, -1);
        checks++;
        if (error !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL len_eq_depth: got error=%b busy=%b rdy=%b required 0 1 1", error, busy, in_ready);
        end
        hard_reset();
    endtask

    task automatic test_zero_len();
        clear_log();
        pulse_start();
        fr = '{8'h00, 8'h00, 8'h00};
        send_frame(0, -1);
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || q_wa.size() != 0) begin
            failures++;
            $display("FAIL zero_len: got done=%b error=%b writes=%0d required 1 0 0", done, error, q_wa.size());
        end
    endtask

    task automatic test_pad();
        clear_log();
        pulse_start();
        fr = '{8'h01, 8'h00, 8'h88, 8'h80, 8'h66};
        send_frame(0, -1);
        repeat (2) @(negedge clk);
        checks++;
        if (error !== 1'b1 || err_code !== 2'd2 || done !== 1'b0 || q_wa.size() != 0) begin
            failures++;
            $display("FAIL pad: got error=%b code=%0d done=%b writes=%0d required 1 2 0 0", error, err_code, done, q_wa.size());
        end
    endtask

    task automatic test_bad_chk();
        clear_log();
        pulse_start();
        fr = '{8'h02, 8'h00, 8'h88, 8'h80, 8'h26, 8'h09, 8'h81, 8'h26, 8'h81};
        send_frame(0, -1);
        check_two_writes("bad_chk");
        checks++;
        if (error !== 1'b1 || err_code !== 2'd3 || done !== 1'b0) begin
            failures++;
            $display("FAIL bad_chk status: got error=%b code=%0d done=%b required 1 3 0", error, err_code, done);
        end
    endtask

    task automatic test_stall();
        clear_log();
        pulse_start();
        fr = '{8'h02, 8'h00, 8'h88, 8'h80, 8'h26, 8'h09, 8'h81, 8'h26, 8'h80};
        send_frame(5, 2);
        check_two_writes("stall");
        checks++;
        if (done !== 1'b1 || err_code !== 2'd0) begin
            failures++;
            $display("FAIL stall status: got done=%b code=%0d required 1 0", done, err_code);
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        pulse_start();
        fr = '{8'h02, 8'h00, 8'h88, 8'h80, 8'h26, 8'h09};
        send_frame(0, -1);
        reset = 1'b1;
        #1;
        checks++;
        if (we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || wa !== 22'h0 || wd !== 22'h0) begin
            failures++;
            $display("FAIL reset_mid outputs: got we=%b busy=%b rdy=%b wa=%h wd=%h required all 0", we, busy, in_ready, wa, wd);
        end
        checks++;
        if (q_wa.size() != 1) begin
            failures++;
            $display("FAIL reset_mid writes: got %0d required 1", q_wa.size());
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_load_two();
    endtask

    initial begin
        test_reset();
        test_load_two();
        test_len_too_big();
        test_zero_len();
        test_pad();
        test_bad_chk();
        test_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
